// File: rtl/uart_gpio_expander_pkg.sv
// ---------------------------------------------------------------------------
// uart_gpio_expander_pkg
// Shared constants and types for the UART-controlled GPIO expander:
// command opcodes, pin map, ASCII read responses and FSM state encodings.
// ---------------------------------------------------------------------------
package uart_gpio_expander_pkg;

  // Command opcodes carried in byte[7:5]
  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_SET = 3'd1;
  localparam logic [2:0] OP_OUT = 3'd2;
  localparam logic [2:0] OP_IN  = 3'd3;
  localparam logic [2:0] OP_RD  = 3'd4;

  // Pin map
  localparam int NUM_GPIO  = 30;
  localparam int GPIO_BASE = 2;
  localparam int RX_PIN    = 0;
  localparam int TX_PIN    = 1;

  // Read responses
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_1 = 8'h31;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Map a pin level onto its ASCII read response
  function automatic logic [7:0] ascii_bit(input logic b);
    return b ? ASCII_1 : ASCII_0;
  endfunction

endpackage

// File: rtl/uart_gpio_expander_rx.sv
// ---------------------------------------------------------------------------
// fabric_uart_rx
// 8N1 UART receiver, LSB first, with a 2-flop input synchronizer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_rx         : raw serial line (idle high)
//   o_rx_valid   : one-cycle pulse when a byte with a good stop bit arrives
//   o_rx_data    : received byte, valid while o_rx_valid is high
// ---------------------------------------------------------------------------
module fabric_uart_rx
  import uart_gpio_expander_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic        r_sync1, r_sync2;
  rx_state_t   r_state, w_state_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [2:0]  r_bit, w_bit_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic        r_ferr, w_ferr_nx;
  logic        r_valid, w_valid_nx;
  logic [7:0]  r_data, w_data_nx;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_ferr  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_ferr  <= w_ferr_nx;
      r_valid <= w_valid_nx;
      r_data  <= w_data_nx;
    end
  end

  // RX next-state: bits are sampled once per bit period at mid-bit
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_ferr_nx  = r_ferr;
    w_valid_nx = 1'b0;
    w_data_nx  = r_data;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nx = 16'd0;
        if (!r_sync2) begin
          w_state_nx = RX_START;
        end else begin
          w_state_nx = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nx = 16'd0;
          // Line back high at mid start bit: treat as a glitch
          if (!r_sync2) begin
            w_state_nx = RX_DATA;
            w_bit_nx   = 3'd0;
          end else begin
            w_state_nx = RX_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nx   = 16'd0;
          w_shift_nx = {r_sync2, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nx = RX_STOP;
          end else begin
            w_bit_nx = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (r_ferr) begin
          // Framing error: park here until the line returns high
          if (r_sync2) begin
            w_state_nx = RX_IDLE;
            w_ferr_nx  = 1'b0;
          end else begin
            w_state_nx = RX_STOP;
          end
        end else if (r_cnt == FULL_M1) begin
          w_cnt_nx = 16'd0;
          if (r_sync2) begin
            w_valid_nx = 1'b1;
            w_data_nx  = r_shift;
            w_state_nx = RX_IDLE;
          end else begin
            w_ferr_nx = 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nx = RX_IDLE;
        w_cnt_nx   = 16'd0;
        w_ferr_nx  = 1'b0;
      end
    endcase
  end

  assign o_rx_valid = r_valid;
  assign o_rx_data  = r_data;

endmodule

// File: rtl/uart_gpio_expander.sv
// ---------------------------------------------------------------------------
// uart_gpio_expander
// UART-controlled 30-bit GPIO expander. Each received byte is a command
// {op[2:0], idx[4:0]} that sets/clears an output, changes a pin direction
// or reads a pin back as ASCII '0'/'1' over the TX line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   io_in      : pad inputs   (io_in[0] = UART RX, io_in[31:2] = GPIO)
//   io_out     : pad outputs  (io_out[1] = UART TX, io_out[31:2] = GPIO)
//   io_oeb     : output-enable bar per pad (1 = input)
// ---------------------------------------------------------------------------
module uart_gpio_expander
  import uart_gpio_expander_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_in,
  output logic [31:0] io_out,
  output logic [31:0] io_oeb
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic                w_rx_valid;
  logic [7:0]          w_rx_data;
  logic [2:0]          w_op;
  logic [4:0]          w_idx;
  logic                w_cmd;
  logic                w_rd_req;
  logic [7:0]          w_rd_byte;
  logic                w_unused_tx_in;

  logic [NUM_GPIO-1:0] r_gsync1, r_gsync2;
  logic [NUM_GPIO-1:0] r_gpio_out, r_gpio_oeb;

  tx_state_t           r_tx_state, w_tx_state_nx;
  logic [15:0]         r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]          r_tx_bit, w_tx_bit_nx;
  logic [7:0]          r_tx_shift, w_tx_shift_nx;
  logic                r_tx_line, w_tx_line_nx;
  logic                r_pend_valid, w_pend_valid_nx;
  logic [7:0]          r_pend_data, w_pend_data_nx;
  logic                w_rd_taken;

  fabric_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (io_in[RX_PIN]),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data)
  );

  // The TX pad is output-only; its input value is never looked at
  assign w_unused_tx_in = io_in[TX_PIN];

  assign w_op      = w_rx_data[7:5];
  assign w_idx     = w_rx_data[4:0];
  // idx 30/31 have no pin and are ignored entirely
  assign w_cmd     = w_rx_valid && (w_idx < 5'd30);
  assign w_rd_req  = w_cmd && (w_op == OP_RD);
  assign w_rd_byte = ascii_bit(r_gsync2[w_idx]);

  // GPIO input synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gsync1 <= {NUM_GPIO{1'b0}};
      r_gsync2 <= {NUM_GPIO{1'b0}};
    end else begin
      r_gsync1 <= io_in[GPIO_BASE +: NUM_GPIO];
      r_gsync2 <= r_gsync1;
    end
  end

  // GPIO output and direction registers, updated by write/direction commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_out <= {NUM_GPIO{1'b0}};
      r_gpio_oeb <= {NUM_GPIO{1'b1}};
    end else if (w_cmd) begin
      case (w_op)
        OP_CLR:  r_gpio_out[w_idx] <= 1'b0;
        OP_SET:  r_gpio_out[w_idx] <= 1'b1;
        OP_OUT:  r_gpio_oeb[w_idx] <= 1'b0;
        OP_IN:   r_gpio_oeb[w_idx] <= 1'b1;
        default: r_gpio_out <= r_gpio_out;
      endcase
    end else begin
      r_gpio_out <= r_gpio_out;
    end
  end

  // TX state, datapath and pending-response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state   <= TX_IDLE;
      r_tx_cnt     <= 16'd0;
      r_tx_bit     <= 3'd0;
      r_tx_shift   <= 8'd0;
      r_tx_line    <= 1'b1;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 8'd0;
    end else begin
      r_tx_state   <= w_tx_state_nx;
      r_tx_cnt     <= w_tx_cnt_nx;
      r_tx_bit     <= w_tx_bit_nx;
      r_tx_shift   <= w_tx_shift_nx;
      r_tx_line    <= w_tx_line_nx;
      r_pend_valid <= w_pend_valid_nx;
      r_pend_data  <= w_pend_data_nx;
    end
  end

  // TX next-state; the line level is registered together with the state
  always_comb begin
    w_tx_state_nx   = r_tx_state;
    w_tx_cnt_nx     = r_tx_cnt;
    w_tx_bit_nx     = r_tx_bit;
    w_tx_shift_nx   = r_tx_shift;
    w_tx_line_nx    = r_tx_line;
    w_pend_valid_nx = r_pend_valid;
    w_pend_data_nx  = r_pend_data;
    w_rd_taken      = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_line_nx = 1'b1;
        if (w_rd_req) begin
          w_tx_state_nx = TX_START;
          w_tx_cnt_nx   = 16'd0;
          w_tx_shift_nx = w_rd_byte;
          w_tx_line_nx  = 1'b0;
          w_rd_taken    = 1'b1;
        end else begin
          w_tx_state_nx = TX_IDLE;
        end
      end
      TX_START: begin
        if (r_tx_cnt == FULL_M1) begin
          w_tx_cnt_nx   = 16'd0;
          w_tx_state_nx = TX_DATA;
          w_tx_bit_nx   = 3'd0;
          w_tx_line_nx  = r_tx_shift[0];
        end else begin
          w_tx_cnt_nx = r_tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == FULL_M1) begin
          w_tx_cnt_nx = 16'd0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nx = TX_STOP;
            w_tx_line_nx  = 1'b1;
          end else begin
            w_tx_bit_nx   = r_tx_bit + 3'd1;
            w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
            w_tx_line_nx  = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == FULL_M1) begin
          w_tx_cnt_nx = 16'd0;
          // End of frame: the pending response goes first, then a read
          // arriving in this very cycle, else back to idle
          if (r_pend_valid) begin
            w_tx_state_nx   = TX_START;
            w_tx_shift_nx   = r_pend_data;
            w_tx_line_nx    = 1'b0;
            w_pend_valid_nx = 1'b0;
          end else if (w_rd_req) begin
            w_tx_state_nx = TX_START;
            w_tx_shift_nx = w_rd_byte;
            w_tx_line_nx  = 1'b0;
            w_rd_taken    = 1'b1;
          end else begin
            w_tx_state_nx = TX_IDLE;
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt + 16'd1;
        end
      end
      default: begin
        w_tx_state_nx = TX_IDLE;
        w_tx_cnt_nx   = 16'd0;
        w_tx_line_nx  = 1'b1;
      end
    endcase
    // A read the transmitter could not take goes to pending if there is room
    if (w_rd_req && !w_rd_taken && !w_pend_valid_nx) begin
      w_pend_valid_nx = 1'b1;
      w_pend_data_nx  = w_rd_byte;
    end else begin
      w_pend_data_nx = w_pend_data_nx;
    end
  end

  // RX pad is always an input driving 0; TX pad is always an output
  assign io_out = {r_gpio_out, r_tx_line, 1'b0};
  assign io_oeb = {r_gpio_oeb, 1'b0, 1'b1};

endmodule

// File: tb/tb_uart_gpio_expander.sv
module tb_uart_gpio_expander;

  localparam int CPB = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] io_in;
  logic [31:0] io_out;
  logic [31:0] io_oeb;

  int checks   = 0;
  int failures = 0;

  uart_gpio_expander #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one 8N1 frame on io_in[0]; called and returns on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    io_in[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_in[0] = b[i];
      repeat (CPB) @(negedge clk);
    end
    io_in[0] = stop;
    repeat (CPB) @(negedge clk);
    io_in[0] = 1'b1;
  endtask

  task automatic wait_rx_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (dut.u_rx.o_rx_valid === 1'b1) seen = 1'b1;
    end
  endtask

  // Wait up to budget cycles for a start bit on io_out[1], then decode it
  task automatic get_tx_frame(input int budget, output bit got, output int lat,
                              output logic [7:0] data, output bit framed_ok);
    got = 1'b0; lat = 0; data = 8'h00; framed_ok = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (io_out[1] === 1'b0) got = 1'b1;
    end
    if (got) begin
      repeat (CPB / 2) @(negedge clk);
      if (io_out[1] !== 1'b0) framed_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        data[i] = io_out[1];
      end
      repeat (CPB) @(negedge clk);
      if (io_out[1] !== 1'b1) framed_ok = 1'b0;
    end
  endtask

  // Watch the TX line for a number of cycles
  task automatic tx_quiet(input int cycles, output bit quiet);
    quiet = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (io_out[1] !== 1'b1) quiet = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    io_in = 32'h0000_0001;
    repeat (3) @(negedge clk);
    checks++;
    if (io_out !== 32'h0000_0002) begin failures++; $display("FAIL reset_out_held: got %h want %h", io_out, 32'h0000_0002); end
    checks++;
    if (io_oeb !== 32'hFFFF_FFFD) begin failures++; $display("FAIL reset_oeb_held: got %h want %h", io_oeb, 32'hFFFF_FFFD); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (io_out !== 32'h0000_0002) begin failures++; $display("FAIL reset_out_released: got %h want %h", io_out, 32'h0000_0002); end
    checks++;
    if (io_oeb !== 32'hFFFF_FFFD) begin failures++; $display("FAIL reset_oeb_released: got %h want %h", io_oeb, 32'hFFFF_FFFD); end
  endtask

  // 0x25 = set g5 (io[7])
  task automatic test_set;
    bit seen;
    fork
      send_byte(8'h25, 1'b1);
      begin
        wait_rx_valid(seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL set_rx_valid: got none want pulse"); end
        checks++;
        if (io_out[7] !== 1'b0) begin failures++; $display("FAIL set_before_edge: got %b want 0", io_out[7]); end
        @(negedge clk);
        checks++;
        if (io_out !== 32'h0000_0082) begin failures++; $display("FAIL set_out: got %h want %h", io_out, 32'h0000_0082); end
        checks++;
        if (io_oeb !== 32'hFFFF_FFFD) begin failures++; $display("FAIL set_oeb: got %h want %h", io_oeb, 32'hFFFF_FFFD); end
      end
    join
  endtask

  // 0x45 = g5 output, 0x05 = clear g5, 0x65 = g5 input
  task automatic test_dir;
    send_byte(8'h45, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (io_oeb !== 32'hFFFF_FF7D) begin failures++; $display("FAIL dir_out_oeb: got %h want %h", io_oeb, 32'hFFFF_FF7D); end
    checks++;
    if (io_out !== 32'h0000_0082) begin failures++; $display("FAIL dir_out_out: got %h want %h", io_out, 32'h0000_0082); end
    send_byte(8'h05, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (io_out !== 32'h0000_0002) begin failures++; $display("FAIL clr_out: got %h want %h", io_out, 32'h0000_0002); end
    checks++;
    if (io_oeb !== 32'hFFFF_FF7D) begin failures++; $display("FAIL clr_oeb: got %h want %h", io_oeb, 32'hFFFF_FF7D); end
    send_byte(8'h65, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (io_oeb !== 32'hFFFF_FFFD) begin failures++; $display("FAIL dir_in_oeb: got %h want %h", io_oeb, 32'hFFFF_FFFD); end
  endtask

  // 0x82 = read g2 (io[4])
  task automatic test_read(input logic level, input logic [7:0] want);
    bit seen, got, ok;
    int lat;
    logic [7:0] data;
    io_in[4] = level;
    repeat (4) @(negedge clk);
    fork
      send_byte(8'h82, 1'b1);
      begin
        wait_rx_valid(seen);
        get_tx_frame(2, got, lat, data, ok);
        checks++;
        if (!seen || !got) begin failures++; $display("FAIL read_start_latency: got start=%0d lat=%0d want start within 2", got, lat); end
        checks++;
        if (data !== want) begin failures++; $display("FAIL read_data: got %h want %h", data, want); end
        checks++;
        if (!ok) begin failures++; $display("FAIL read_framing: got bad start/stop want good"); end
      end
    join
  endtask

  // Reads of g0=1, g1=0, g2=1 sent with no idle gap between frames
  task automatic test_back_to_back;
    bit         got_a [3];
    bit         ok_a  [3];
    logic [7:0] dat_a [3];
    int         lat;
    io_in[4:2] = 3'b101;
    repeat (4) @(negedge clk);
    fork
      begin
        send_byte(8'h80, 1'b1);
        send_byte(8'h81, 1'b1);
        send_byte(8'h82, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          get_tx_frame((k == 0) ? 400 : 200, got_a[k], lat, dat_a[k], ok_a[k]);
        end
      end
    join
    checks++;
    if (!got_a[0] || !ok_a[0] || dat_a[0] !== 8'h31) begin failures++; $display("FAIL b2b_first: got valid=%0d ok=%0d data=%h want 31", got_a[0], ok_a[0], dat_a[0]); end
    checks++;
    if (!got_a[1] || !ok_a[1] || dat_a[1] !== 8'h30) begin failures++; $display("FAIL b2b_second: got valid=%0d ok=%0d data=%h want 30", got_a[1], ok_a[1], dat_a[1]); end
    checks++;
    if (got_a[2] && (!ok_a[2] || dat_a[2] !== 8'h31)) begin failures++; $display("FAIL b2b_third: got ok=%0d data=%h want 31 or dropped", ok_a[2], dat_a[2]); end
  endtask

  // Framing error, idx 31/30 commands, reserved op and a short glitch
  task automatic test_errors;
    bit quiet;
    fork
      begin
        send_byte(8'h2A, 1'b0);
        repeat (4) @(negedge clk);
        send_byte(8'h3F, 1'b1);
        send_byte(8'h9E, 1'b1);
        send_byte(8'hA7, 1'b1);
        io_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        io_in[0] = 1'b1;
        repeat (40) @(negedge clk);
      end
      tx_quiet(4 * 10 * CPB + 48, quiet);
    join
    checks++;
    if (io_out !== 32'h0000_0002) begin failures++; $display("FAIL err_out: got %h want %h", io_out, 32'h0000_0002); end
    checks++;
    if (io_oeb !== 32'hFFFF_FFFD) begin failures++; $display("FAIL err_oeb: got %h want %h", io_oeb, 32'hFFFF_FFFD); end
    checks++;
    if (!quiet) begin failures++; $display("FAIL err_tx_quiet: got TX activity want none"); end
    // The receiver must still accept a good frame afterwards (set g10 = io[12])
    send_byte(8'h2A, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (io_out !== 32'h0000_1002) begin failures++; $display("FAIL err_recover: got %h want %h", io_out, 32'h0000_1002); end
  endtask

  task automatic test_reset_mid_tx;
    bit seen, quiet;
    io_in[4] = 1'b1;
    repeat (4) @(negedge clk);
    fork
      send_byte(8'h82, 1'b1);
      begin
        wait_rx_valid(seen);
        repeat (40) @(negedge clk);
      end
    join
    rst_n = 1'b0;
    #1;
    checks++;
    if (io_out !== 32'h0000_0002) begin failures++; $display("FAIL rst_tx_out: got %h want %h", io_out, 32'h0000_0002); end
    checks++;
    if (io_oeb !== 32'hFFFF_FFFD) begin failures++; $display("FAIL rst_tx_oeb: got %h want %h", io_oeb, 32'hFFFF_FFFD); end
    @(negedge clk);
    rst_n = 1'b1;
    tx_quiet(200, quiet);
    checks++;
    if (!quiet) begin failures++; $display("FAIL rst_tx_partial: got TX activity want idle"); end
    send_byte(8'h25, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (io_out !== 32'h0000_0082) begin failures++; $display("FAIL rst_tx_next_cmd: got %h want %h", io_out, 32'h0000_0082); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_dir();
    test_read(1'b1, 8'h31);
    test_read(1'b0, 8'h30);
    test_back_to_back();
    test_errors();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
